rob_alloc_ctrl: RTL

- Sequences the ID->ROB pipeline register and allocates reorder-buffer entries.
- Each cycle, decides whether the instruction held in the ID/ROB register dispatches, assigns it a ROB tag, and commits from the ROB head.
- Generates the stall for the ID/ROB register and runs a post-flush recovery window.
- Sits between the ID/ROB register, the ROB storage array and the issue queue.

---
 rtl/rob_alloc_ctrl_if.sv | 37 +++
 rtl/rob_alloc_ctrl.sv | 108 ++++++++++
 2 files changed

// File: rtl/rob_alloc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : rob_alloc_ctrl_if
// Brief    : Dispatch/commit handshake bundle between the ID/ROB stage, the
//            ROB storage array and the issue queue.
// Revision : 1.0
// ============================================================================
interface rob_alloc_ctrl_if #(
  parameter int ROB_ADDR_WIDTH = 4
);
  logic                      flush;
  logic                      idrob_valid;
  logic                      iq_ready;
  logic                      head_done;
  logic                      alloc_en;
  logic [ROB_ADDR_WIDTH-1:0] alloc_tag;
  logic                      stall_idrob;
  logic                      commit_en;
  logic [ROB_ADDR_WIDTH-1:0] commit_tag;
  logic [ROB_ADDR_WIDTH:0]   rob_count;
  logic                      rob_full;
  logic                      rob_empty;
  logic                      recovering;

  modport master (
    output flush, idrob_valid, iq_ready, head_done,
    input  alloc_en, alloc_tag, stall_idrob, commit_en, commit_tag,
    input  rob_count, rob_full, rob_empty, recovering
  );

  modport slave (
    input  flush, idrob_valid, iq_ready, head_done,
    output alloc_en, alloc_tag, stall_idrob, commit_en, commit_tag,
    output rob_count, rob_full, rob_empty, recovering
  );
endinterface
`default_nettype wire

// File: rtl/rob_alloc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rob_alloc_ctrl
// Brief    : ROB entry allocation/commit control with ID/ROB stall generation
//            and a fixed-length post-flush recovery window.
// Revision : 1.0
// ============================================================================
module rob_alloc_ctrl #(
  parameter int ROB_ADDR_WIDTH = 4,
  parameter int FLUSH_PENALTY  = 2
) (
  input  wire logic        clk,
  input  wire logic        rst,
  rob_alloc_ctrl_if.slave  bus
);
  localparam int c_PTR_W = ROB_ADDR_WIDTH + 1;
  localparam int c_PEN_W = 4;
  localparam logic [c_PEN_W-1:0] c_PENALTY = c_PEN_W'(FLUSH_PENALTY);

  typedef enum logic [0:0] {
    ST_NORMAL  = 1'b0,
    ST_RECOVER = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_PEN_W-1:0]   r_pen_cnt;
  logic [c_PEN_W-1:0]   w_pen_cnt_nxt;
  logic [c_PTR_W-1:0]   r_head;
  logic [c_PTR_W-1:0]   r_tail;

  logic w_full;
  logic w_empty;
  logic w_alloc;
  logic w_commit;

  // Wrap bits distinguish full from empty when the index bits coincide.
  assign w_empty = (r_head == r_tail);
  assign w_full  = (r_head[ROB_ADDR_WIDTH-1:0] == r_tail[ROB_ADDR_WIDTH-1:0]) &&
                   (r_head[ROB_ADDR_WIDTH] != r_tail[ROB_ADDR_WIDTH]);

  assign w_alloc  = bus.idrob_valid && bus.iq_ready && !w_full &&
                    (r_state == ST_NORMAL) && !bus.flush;
  assign w_commit = bus.head_done && !w_empty && !bus.flush;

  assign bus.alloc_en    = w_alloc;
  assign bus.alloc_tag   = r_tail[ROB_ADDR_WIDTH-1:0];
  assign bus.stall_idrob = bus.idrob_valid && !w_alloc && !bus.flush;
  assign bus.commit_en   = w_commit;
  assign bus.commit_tag  = r_head[ROB_ADDR_WIDTH-1:0];
  assign bus.rob_count   = r_tail - r_head;
  assign bus.rob_full    = w_full;
  assign bus.rob_empty   = w_empty;
  assign bus.recovering  = (r_state == ST_RECOVER);

  always_comb begin
    w_state_nxt   = r_state;
    w_pen_cnt_nxt = r_pen_cnt;
    case (r_state)
      ST_NORMAL: begin
        if (bus.flush) begin
          w_state_nxt   = ST_RECOVER;
          w_pen_cnt_nxt = c_PENALTY;
        end
      end
      ST_RECOVER: begin
        if (bus.flush) begin
          w_pen_cnt_nxt = c_PENALTY;
        end else if (r_pen_cnt == c_PEN_W'(1)) begin
          w_state_nxt   = ST_NORMAL;
          w_pen_cnt_nxt = '0;
        end else begin
          w_pen_cnt_nxt = r_pen_cnt - c_PEN_W'(1);
        end
      end
      default: begin
        w_state_nxt   = ST_NORMAL;
        w_pen_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_NORMAL;
      r_pen_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pen_cnt <= w_pen_cnt_nxt;
    end
  end

  // A flush empties the ROB outright; in-flight alloc/commit are squashed.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_alloc) begin
        r_tail <= r_tail + c_PTR_W'(1);
      end
      if (w_commit) begin
        r_head <= r_head + c_PTR_W'(1);
      end
    end
  end
endmodule
`default_nettype wire
